mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the RISC-V console CPU. It sits between execute and writeback: it consumes an `ExecInst` from execute, performs the data-memory access for loads and stores, and emits a writeback record. Memory access uses a request/grant/response handshake, byte-lane steering, and load sign- or zero-extension. Non-memory instructions pass through after one registered cycle.

## Interface
Parameters
- `TIMEOUT_CYCLES`, default 255: cycles spent waiting in REQ+WAIT before the stage declares a bus error.

Ports (clock and reset first)
- `clk_in`  in  1  system clock.
- `rst_n_in`  in  1  reset, asynchronous, active-low.
- `ex_valid_in`  in  1  execute offers an instruction.
- `ex_inst_in`  in  `ExecInst`  fields iType, memFunc, dst, data, addr, nextPc.
- `ex_ready_out`  out  1  stage can accept; high only in IDLE.
- `dmem_req_out`  out  1  memory request.
- `dmem_we_out`  out  1  1 = store.
- `dmem_addr_out`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `dmem_wdata_out`  out  32  lane-shifted store data.
- `dmem_be_out`  out  4  byte enables; 0 on loads.
- `dmem_gnt_in`  in  1  request accepted.
- `dmem_rvalid_in`  in  1  load data valid.
- `dmem_rdata_in`  in  32  raw load word.
- `wb_valid_out`  out  1  writeback record valid.
- `wb_ready_in`  in  1  writeback accepts the record.
- `wb_we_out`  out  1  write the register file.
- `wb_dst_out`  out  5  destination register.
- `wb_data_out`  out  32  writeback value.
- `err_out`  out  1  sticky error flag.
- `err_addr_out`  out  32  address of the faulting access.

## Operation
- FSM states: IDLE, REQ, WAIT, WB, ERR.
- **IDLE**
  - An instruction is accepted when `ex_valid_in && ex_ready_out`. The stage latches `ex_inst_in`.
  - memFunc NopM: go to WB. `wb_data_out` = data.
  - Load or store: go to REQ.
- **REQ**
  - `dmem_req_out` = 1. Address, write data and byte enables stay stable until `dmem_gnt_in`.
  - Store granted: go to WB.
  - Load granted with `dmem_rvalid_in` in the same cycle: go to WB.
  - Load granted without `dmem_rvalid_in`: go to WAIT.
- **WAIT**: on `dmem_rvalid_in`, capture the extended data and go to WB.
- **WB**: hold `wb_valid_out` until `wb_ready_in`, then go to IDLE.
- **ERR**
  - Terminal until reset.
  - `err_out` = 1 and `ex_ready_out` = 0.
  - No further dmem requests are issued.
- `wb_we_out` rules:
  - 1 when dst != 0 and iType is one of OP, OPIMM, LUI, JAL, JALR, AUIPC, PMUL, LOAD.
  - 0 for BRANCH, STORE and Unsupported. Those instructions still retire through WB.
- Byte-lane steering uses offset `o = addr[1:0]`.
  - Sb: be = `4'b0001<<o`, wdata = `data[7:0]` replicated to all lanes.
  - Sh: be = `4'b0011<<{o[1],1'b0}`, wdata = `data[15:0]` replicated.
  - Sw: be = 4'hF, wdata = data.
- Load extension:
  - Lb/Lbu: byte at lane o, sign- or zero-extended.
  - Lh/Lhu: half at lane `o[1]`, sign- or zero-extended.
  - Lw: full word.
- Timeout: a counter resets on entry to REQ and runs through REQ and WAIT. When it reaches `TIMEOUT_CYCLES`, go to ERR with `err_addr_out` = addr.

## Timing
- Reset values: state IDLE. All outputs 0, except `ex_ready_out` = 1.
- Asserting reset mid-transaction drops `dmem_req_out` immediately and discards the held instruction.
- `ex_ready_out` is a combinational decode of state. All other outputs are registered.
- Latency from accept to `wb_valid_out`:
  - Non-memory: 1 cycle.
  - Store: 1 cycle + grant wait.
  - Load: 1 cycle + grant wait + rvalid wait, minimum 2 cycles.
- Throughput: at most one instruction every 2 cycles, because the stage returns to IDLE between instructions.
- An `ex_valid_in` arriving while busy is ignored. Execute must hold it until `ex_ready_out`.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - Lw/Sw with `addr[1:0]` != 0 is misaligned.
  - Lh/Lhu/Sh with `addr[0]` = 1 is misaligned.
  - A misaligned access goes IDLE→ERR on the cycle after accept, with no dmem request and `err_addr_out` = addr.
- Not defined: the low address bits beyond the access size are silently ignored. Word accesses use the aligned word; half accesses use `addr[1]`.

## Structure
- Add to the shared `ProcTypes` package:
  - `MemState` enum.
  - `WbInst` struct {dst, data, we}.
  - `TIMEOUT_CYCLES` default constant.
- One combinational sub-module, `mem_lane_align`:
  - Store side: memFunc, offset, data → be, wdata.
  - Load side: memFunc, offset, rdata → extended value.

## Test plan
- OP, dst=5, data=32'h1234: `wb_valid_out` 1 cycle after accept; we=1, dst=5, data=32'h1234. Same with dst=0 → we=0.
- Sb, addr=32'h103, data=32'hAB: `dmem_addr_out`=32'h100, be=4'b1000, wdata=32'hABABABAB. WB with we=0.
- Lb, addr=32'h102, rdata=32'h0080_0000, rvalid 3 cycles after gnt → data=32'hFFFF_FF80. Lbu with the same stimulus → 32'h0000_0080.
- Hold `dmem_gnt_in` low for 255 cycles on a Lw at 32'h40: `err_out`=1, `err_addr_out`=32'h40, `ex_ready_out` stays 0.
- Assert reset while in WAIT: next cycle state IDLE, `dmem_req_out`=0, `wb_valid_out`=0.
- With `MEM_MISALIGN_TRAP_EN`, Lw at 32'h42: no `dmem_req_out`, `err_out`=1. Without the macro: request at 32'h40, data = rdata.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// ProcTypes: shared type definitions for the console CPU pipeline, including
// the memory-stage types.
//   IType / MemFunc : instruction class and memory function decodes
//   ExecInst        : record handed from execute to the memory stage
//   MemState        : memory-stage FSM states
//   WbInst          : writeback record {dst, data, we}
//   DEFAULT_TIMEOUT_CYCLES : default bus timeout for the memory stage
package ProcTypes;

  typedef enum logic [3:0] {
    OP, OPIMM, BRANCH, LUI, JAL, JALR, LOAD, STORE, AUIPC, PMUL, Unsupported
  } IType;

  typedef enum logic [3:0] {
    NopM, Lw, Lh, Lhu, Lb, Lbu, Sw, Sh, Sb
  } MemFunc;

  typedef struct packed {
    IType        iType;
    MemFunc      memFunc;
    logic [4:0]  dst;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] nextPc;
  } ExecInst;

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, WB, ERR
  } MemState;

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] data;
    logic        we;
  } WbInst;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  function automatic logic is_load(input MemFunc f);
    return (f == Lw) || (f == Lh) || (f == Lhu) || (f == Lb) || (f == Lbu);
  endfunction

  function automatic logic is_store(input MemFunc f);
    return (f == Sw) || (f == Sh) || (f == Sb);
  endfunction

  // Register-file write enable: only result-producing classes write, and x0
  // is never written.
  function automatic logic wb_writes(input IType t, input logic [4:0] dst);
    logic writes;
    case (t)
      OP, OPIMM, LUI, JAL, JALR, AUIPC, PMUL, LOAD: writes = 1'b1;
      default:                                      writes = 1'b0;
    endcase
    return writes && (dst != 5'd0);
  endfunction

  // Word accesses need offset 0, half accesses need an even offset.
  function automatic logic is_misaligned(input MemFunc f, input logic [1:0] off);
    case (f)
      Lw, Sw:      return off != 2'b00;
      Lh, Lhu, Sh: return off[0];
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the memory stage.
//   mem_func_in  : memory function of the access
//   offset_in    : byte offset addr[1:0]
//   st_data_in   : unshifted store data
//   ld_rdata_in  : raw load word from memory
//   be_out       : store byte enables (0 for non-stores)
//   wdata_out    : store data replicated across lanes
//   ld_data_out  : sign/zero-extended load value
module mem_lane_align
  import ProcTypes::*;
(
  input  MemFunc      mem_func_in,
  input  logic [1:0]  offset_in,
  input  logic [31:0] st_data_in,
  input  logic [31:0] ld_rdata_in,
  output logic [3:0]  be_out,
  output logic [31:0] wdata_out,
  output logic [31:0] ld_data_out
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Half accesses only look at offset bit 1; bit 0 is ignored (or trapped
  // upstream when misalignment trapping is enabled).
  assign ld_byte = ld_rdata_in[{offset_in, 3'b000} +: 8];
  assign ld_half = ld_rdata_in[{offset_in[1], 4'b0000} +: 16];

  always_comb begin
    be_out    = 4'b0000;
    wdata_out = st_data_in;
    case (mem_func_in)
      Sb: begin
        be_out    = 4'b0001 << offset_in;
        wdata_out = {4{st_data_in[7:0]}};
      end
      Sh: begin
        be_out    = 4'b0011 << {offset_in[1], 1'b0};
        wdata_out = {2{st_data_in[15:0]}};
      end
      Sw: begin
        be_out    = 4'hF;
        wdata_out = st_data_in;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data_out = ld_rdata_in;
    case (mem_func_in)
      Lb:      ld_data_out = {{24{ld_byte[7]}}, ld_byte};
      Lbu:     ld_data_out = {24'd0, ld_byte};
      Lh:      ld_data_out = {{16{ld_half[15]}}, ld_half};
      Lhu:     ld_data_out = {16'd0, ld_half};
      default: ld_data_out = ld_rdata_in;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and writeback.
// Accepts one ExecInst when idle, performs a load/store over a
// request/grant/response bus, and emits a writeback record.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned word/half
// accesses go straight to the error state instead of being aligned down).
//
// Handshakes (all valid/ready style):
//   ex_valid_in/ex_ready_out : transfer when both high on a clock edge;
//                              ex_ready_out is high only in IDLE.
//   dmem_req_out/dmem_gnt_in : request and its attributes hold stable until
//                              a cycle with dmem_gnt_in high; load data then
//                              arrives on a cycle with dmem_rvalid_in high
//                              (possibly the grant cycle itself).
//   wb_valid_out/wb_ready_in : record holds until wb_ready_in is high.
//
// Ports: clk_in, rst_n_in (async active-low), ex_* (execute side),
// dmem_* (data memory), wb_* (writeback), err_out/err_addr_out (sticky error).
module mem_stage
  import ProcTypes::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        ex_valid_in,
  input  ExecInst     ex_inst_in,
  output logic        ex_ready_out,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_be_out,
  input  logic        dmem_gnt_in,
  input  logic        dmem_rvalid_in,
  input  logic [31:0] dmem_rdata_in,
  output logic        wb_valid_out,
  input  logic        wb_ready_in,
  output logic        wb_we_out,
  output logic [4:0]  wb_dst_out,
  output logic [31:0] wb_data_out,
  output logic        err_out,
  output logic [31:0] err_addr_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  MemState          state_q, state_d;
  ExecInst          inst_q, inst_d;
  WbInst            wb_q, wb_d;
  logic             wb_valid_q, wb_valid_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             err_q, err_d;
  logic [31:0]      err_addr_q, err_addr_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;

  logic        accept;
  logic        misaligned;
  MemFunc      align_func;
  logic [1:0]  align_off;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        unused_ok;

  assign ex_ready_out = (state_q == IDLE);
  assign accept       = ex_valid_in && ex_ready_out;

  // In IDLE the aligner steers the incoming store; afterwards it extends
  // load data for the held instruction.
  assign align_func = (state_q == IDLE) ? ex_inst_in.memFunc : inst_q.memFunc;
  assign align_off  = (state_q == IDLE) ? ex_inst_in.addr[1:0] : inst_q.addr[1:0];

  mem_lane_align u_align (
    .mem_func_in (align_func),
    .offset_in   (align_off),
    .st_data_in  (ex_inst_in.data),
    .ld_rdata_in (dmem_rdata_in),
    .be_out      (st_be),
    .wdata_out   (st_wdata),
    .ld_data_out (ld_data)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = is_misaligned(ex_inst_in.memFunc, ex_inst_in.addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // nextPc travels with the instruction but is not consumed here.
  assign unused_ok = ^{ex_inst_in.nextPc, inst_q.nextPc};

  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    wb_d       = wb_q;
    wb_valid_d = wb_valid_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    tmo_d      = tmo_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          inst_d  = ex_inst_in;
          wb_d.dst  = ex_inst_in.dst;
          wb_d.we   = wb_writes(ex_inst_in.iType, ex_inst_in.dst);
          wb_d.data = ex_inst_in.data;
          if (misaligned) begin
            state_d    = ERR;
            err_d      = 1'b1;
            err_addr_d = ex_inst_in.addr;
          end else if (is_load(ex_inst_in.memFunc) || is_store(ex_inst_in.memFunc)) begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = is_store(ex_inst_in.memFunc);
            addr_d  = {ex_inst_in.addr[31:2], 2'b00};
            be_d    = st_be;
            wdata_d = is_store(ex_inst_in.memFunc) ? st_wdata : 32'd0;
            tmo_d   = '0;
          end else begin
            state_d    = WB;
            wb_valid_d = 1'b1;
          end
        end
      end

      REQ: begin
        if (dmem_gnt_in) begin
          req_d = 1'b0;
          if (is_store(inst_q.memFunc)) begin
            state_d    = WB;
            wb_valid_d = 1'b1;
          end else if (dmem_rvalid_in) begin
            state_d    = WB;
            wb_valid_d = 1'b1;
            wb_d.data  = ld_data;
          end else begin
            state_d = WAIT;
            tmo_d   = tmo_q + 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d    = ERR;
          req_d      = 1'b0;
          err_d      = 1'b1;
          err_addr_d = inst_q.addr;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      WAIT: begin
        if (dmem_rvalid_in) begin
          state_d    = WB;
          wb_valid_d = 1'b1;
          wb_d.data  = ld_data;
        end else if (tmo_q == TMO_LAST) begin
          state_d    = ERR;
          err_d      = 1'b1;
          err_addr_d = inst_q.addr;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      WB: begin
        if (wb_ready_in) begin
          state_d    = IDLE;
          wb_valid_d = 1'b0;
        end
      end

      ERR: begin
        req_d = 1'b0;
        err_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      inst_q     <= '0;
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      wb_q       <= wb_d;
      wb_valid_q <= wb_valid_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      tmo_q      <= tmo_d;
    end
  end

  assign dmem_req_out   = req_q;
  assign dmem_we_out    = we_q;
  assign dmem_addr_out  = addr_q;
  assign dmem_wdata_out = wdata_q;
  assign dmem_be_out    = be_q;
  assign wb_valid_out   = wb_valid_q;
  assign wb_we_out      = wb_q.we;
  assign wb_dst_out     = wb_q.dst;
  assign wb_data_out    = wb_q.data;
  assign err_out        = err_q;
  assign err_addr_out   = err_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage. Inputs are driven and outputs sampled
// 1 time unit after each rising clock edge.
module tb_mem_stage
  import ProcTypes::*;
;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  ExecInst     ex_inst;
  logic        ex_ready;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        err;
  logic [31:0] err_addr;

  int total;
  int bad;

  mem_stage #(.TIMEOUT_CYCLES(255)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .ex_valid_in    (ex_valid),
    .ex_inst_in     (ex_inst),
    .ex_ready_out   (ex_ready),
    .dmem_req_out   (dmem_req),
    .dmem_we_out    (dmem_we),
    .dmem_addr_out  (dmem_addr),
    .dmem_wdata_out (dmem_wdata),
    .dmem_be_out    (dmem_be),
    .dmem_gnt_in    (dmem_gnt),
    .dmem_rvalid_in (dmem_rvalid),
    .dmem_rdata_in  (dmem_rdata),
    .wb_valid_out   (wb_valid),
    .wb_ready_in    (wb_ready),
    .wb_we_out      (wb_we),
    .wb_dst_out     (wb_dst),
    .wb_data_out    (wb_data),
    .err_out        (err),
    .err_addr_out   (err_addr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ExecInst mk(input IType t, input MemFunc f, input logic [4:0] d,
                                 input logic [31:0] data, input logic [31:0] addr);
    ExecInst i;
    i         = '0;
    i.iType   = t;
    i.memFunc = f;
    i.dst     = d;
    i.data    = data;
    i.addr    = addr;
    i.nextPc  = addr + 32'd4;
    return i;
  endfunction

  task automatic send(input ExecInst i);
    ex_inst  = i;
    ex_valid = 1'b1;
    chk("ready_before_accept", {31'd0, ex_ready}, 32'd1);
    tick();
    ex_valid = 1'b0;
    ex_inst  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic retire();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("retire_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("retire_ready", {31'd0, ex_ready}, 32'd1);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    ex_valid    = 1'b0;
    ex_inst     = '0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    wb_ready    = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    rst_n = 1'b1;
    tick();

    // OP dst=5: one-cycle latency, record held until wb_ready
    send(mk(OP, NopM, 5'd5, 32'h1234, 32'h0));
    chk("op_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("op_we", {31'd0, wb_we}, 32'd1);
    chk("op_dst", {27'd0, wb_dst}, 32'd5);
    chk("op_data", wb_data, 32'h1234);
    chk("op_busy", {31'd0, ex_ready}, 32'd0);
    chk("op_no_req", {31'd0, dmem_req}, 32'd0);
    tick();
    chk("op_hold_valid", {31'd0, wb_valid}, 32'd1);
    retire();

    // OP dst=0: no register write
    send(mk(OP, NopM, 5'd0, 32'h1234, 32'h0));
    chk("op0_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("op0_we", {31'd0, wb_we}, 32'd0);
    retire();

    // BRANCH retires without writing
    send(mk(BRANCH, NopM, 5'd3, 32'h55, 32'h0));
    chk("br_we", {31'd0, wb_we}, 32'd0);
    retire();

    // Sb at 0x103
    send(mk(STORE, Sb, 5'd4, 32'hAB, 32'h103));
    chk("sb_req", {31'd0, dmem_req}, 32'd1);
    chk("sb_we", {31'd0, dmem_we}, 32'd1);
    chk("sb_addr", dmem_addr, 32'h100);
    chk("sb_be", {28'd0, dmem_be}, 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hABABABAB);
    tick();
    chk("sb_req_hold", {31'd0, dmem_req}, 32'd1);
    chk("sb_addr_hold", dmem_addr, 32'h100);
    chk("sb_be_hold", {28'd0, dmem_be}, 32'h8);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("sb_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("sb_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("sb_wb_we", {31'd0, wb_we}, 32'd0);
    retire();

    // Sh at 0x102
    send(mk(STORE, Sh, 5'd0, 32'h12345678, 32'h102));
    chk("sh_addr", dmem_addr, 32'h100);
    chk("sh_be", {28'd0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'h56785678);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("sh_wb_valid", {31'd0, wb_valid}, 32'd1);
    retire();

    // Sw at 0x10
    send(mk(STORE, Sw, 5'd0, 32'hDEADBEEF, 32'h10));
    chk("sw_addr", dmem_addr, 32'h10);
    chk("sw_be", {28'd0, dmem_be}, 32'hF);
    chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    retire();

    // Lb at 0x102, rvalid three cycles after grant
    send(mk(LOAD, Lb, 5'd7, 32'h0, 32'h102));
    chk("lb_req", {31'd0, dmem_req}, 32'd1);
    chk("lb_we", {31'd0, dmem_we}, 32'd0);
    chk("lb_be", {28'd0, dmem_be}, 32'd0);
    chk("lb_addr", dmem_addr, 32'h100);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("lb_wait_req", {31'd0, dmem_req}, 32'd0);
    tick();
    tick();
    chk("lb_wait_valid", {31'd0, wb_valid}, 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0080_0000;
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    chk("lb_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_we_wb", {31'd0, wb_we}, 32'd1);
    chk("lb_dst", {27'd0, wb_dst}, 32'd7);
    retire();

    // Lbu, same stimulus
    send(mk(LOAD, Lbu, 5'd7, 32'h0, 32'h102));
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    tick();
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0080_0000;
    tick();
    dmem_rvalid = 1'b0;
    chk("lbu_data", wb_data, 32'h0000_0080);
    retire();

    // Lh with grant and rvalid together: two-cycle latency
    send(mk(LOAD, Lh, 5'd8, 32'h0, 32'h102));
    dmem_gnt    = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h8001_0000;
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    chk("lh_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("lh_data", wb_data, 32'hFFFF_8001);
    retire();

    // reset while in REQ drops the request immediately
    send(mk(LOAD, Lw, 5'd2, 32'h0, 32'h80));
    chk("rreq_req", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rreq_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("rreq_ready", {31'd0, ex_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // reset while in WAIT
    send(mk(LOAD, Lw, 5'd2, 32'h0, 32'h80));
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("rwait_busy", {31'd0, ex_ready}, 32'd0);
    rst_n = 1'b0;
    tick();
    chk("rwait_ready", {31'd0, ex_ready}, 32'd1);
    chk("rwait_req", {31'd0, dmem_req}, 32'd0);
    chk("rwait_wb_valid", {31'd0, wb_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    send(mk(OPIMM, NopM, 5'd1, 32'h77, 32'h0));
    chk("post_rst_data", wb_data, 32'h77);
    retire();

    // Lw at 0x42
`ifdef MEM_MISALIGN_TRAP_EN
    send(mk(LOAD, Lw, 5'd9, 32'h0, 32'h42));
    chk("mis_no_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_err", {31'd0, err}, 32'd1);
    chk("mis_err_addr", err_addr, 32'h42);
    chk("mis_ready", {31'd0, ex_ready}, 32'd0);
    do_reset();
`else
    send(mk(LOAD, Lw, 5'd9, 32'h0, 32'h42));
    chk("mis_req", {31'd0, dmem_req}, 32'd1);
    chk("mis_addr", dmem_addr, 32'h40);
    dmem_gnt    = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_F00D;
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    chk("mis_data", wb_data, 32'hCAFE_F00D);
    chk("mis_no_err", {31'd0, err}, 32'd0);
    retire();
`endif

    // timeout: grant held low on a Lw at 0x40
    send(mk(LOAD, Lw, 5'd3, 32'h0, 32'h40));
    repeat (254) tick();
    chk("tmo_not_yet", {31'd0, err}, 32'd0);
    chk("tmo_req_still", {31'd0, dmem_req}, 32'd1);
    tick();
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_err_addr", err_addr, 32'h40);
    chk("tmo_ready", {31'd0, ex_ready}, 32'd0);
    chk("tmo_req_drop", {31'd0, dmem_req}, 32'd0);
    ex_valid = 1'b1;
    ex_inst  = mk(OP, NopM, 5'd5, 32'h1, 32'h0);
    tick();
    tick();
    ex_valid = 1'b0;
    chk("err_sticky", {31'd0, err}, 32'd1);
    chk("err_ready_low", {31'd0, ex_ready}, 32'd0);
    chk("err_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("err_no_req", {31'd0, dmem_req}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
